attack_phase_sequencer: RTL and testbench

- Per-player attack controller. It sequences one attack through STARTUP, ACTIVE and RECOVERY phases, and handles hit-stun preemption.
- It owns one external dynamic duration counter (enable/stop/limit/done interface, WIDTH-bit limit), reprogramming its limit at every phase change.
- It sits between the player input/decode logic and the hitbox/sprite logic, and gates movement and hitbox enable.

---
 rtl/attack_phase_sequencer.sv | 178 +++++++++++++++++
 tb/tb_attack_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_phase_sequencer.sv
// Per-player attack controller: runs STARTUP/ACTIVE/RECOVERY on an external duration counter,
// with hit-stun preemption, special cancel out of ACTIVE and a one-deep request buffer in RECOVERY.
module attack_phase_sequencer #(
   parameter int         WIDTH        = 5,
   parameter logic [1:0] SPECIAL_TYPE = 2'd2
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             i_attack_req,
   input  logic [1:0]       i_attack_type,
   input  logic [WIDTH-1:0] i_su_limit,
   input  logic [WIDTH-1:0] i_act_limit,
   input  logic [WIDTH-1:0] i_rec_limit,
   input  logic             i_hit,
   input  logic [WIDTH-1:0] i_stun_limit,
   input  logic             i_cnt_done,
   output logic             o_cnt_enable,
   output logic             o_cnt_stop,
   output logic [WIDTH-1:0] o_cnt_limit,
   output logic [2:0]       o_state,
   output logic [1:0]       o_attack_type,
   output logic             o_accept,
   output logic             o_hitbox_en,
   output logic             o_can_move,
   output logic             o_buf_valid
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_STARTUP  = 3'd1,
      S_ACTIVE   = 3'd2,
      S_RECOVERY = 3'd3,
      S_STUN     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic [1:0]       type_q, type_d;
   logic [WIDTH-1:0] su_q, su_d, act_q, act_d, rec_q, rec_d;
   logic             buf_vld_q, buf_vld_d;
   logic [1:0]       buf_type_q, buf_type_d;
   logic [WIDTH-1:0] buf_su_q, buf_su_d, buf_act_q, buf_act_d, buf_rec_q, buf_rec_d;
   logic             stop_q, enable_q, accept_q, hitbox_q, move_q;
   logic             go, load_new, load_buf, done_ok, cancel;

   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
      return (v == '0) ? WIDTH'(1) : v;
   endfunction

   // A done arriving during the clear cycle belongs to the previous phase.
   assign done_ok = i_cnt_done && !stop_q && (state_q != S_IDLE);
   assign cancel  = i_attack_req && (i_attack_type == SPECIAL_TYPE) && (type_q != SPECIAL_TYPE);

   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      type_d     = type_q;
      su_d       = su_q;
      act_d      = act_q;
      rec_d      = rec_q;
      buf_vld_d  = buf_vld_q;
      buf_type_d = buf_type_q;
      buf_su_d   = buf_su_q;
      buf_act_d  = buf_act_q;
      buf_rec_d  = buf_rec_q;
      go         = 1'b0;
      load_new   = 1'b0;
      load_buf   = 1'b0;
      if (i_hit) begin
         state_d   = S_STUN;
         limit_d   = clamp(i_stun_limit);
         buf_vld_d = 1'b0;
         go        = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: load_new = i_attack_req;
            S_STARTUP: if (done_ok) begin
               state_d = S_ACTIVE;
               limit_d = act_q;
               go      = 1'b1;
            end
            S_ACTIVE: begin
               if (cancel) begin
                  load_new = 1'b1;
               end else if (done_ok) begin
                  state_d = S_RECOVERY;
                  limit_d = rec_q;
                  go      = 1'b1;
               end
            end
            S_RECOVERY: begin
               if (done_ok) begin
                  if (buf_vld_q) begin
                     load_buf  = 1'b1;
                     buf_vld_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     limit_d = '0;
                     go      = 1'b1;
                  end
               end else if (i_attack_req && !buf_vld_q) begin
                  buf_vld_d  = 1'b1;
                  buf_type_d = i_attack_type;
                  buf_su_d   = i_su_limit;
                  buf_act_d  = i_act_limit;
                  buf_rec_d  = i_rec_limit;
               end
            end
            S_STUN: if (done_ok) begin
               state_d = S_IDLE;
               limit_d = '0;
               go      = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
               limit_d = '0;
               go      = 1'b1;
            end
         endcase
      end
      if (load_new || load_buf) begin
         state_d = S_STARTUP;
         go      = 1'b1;
         type_d  = load_buf ? buf_type_q : i_attack_type;
         su_d    = clamp(load_buf ? buf_su_q  : i_su_limit);
         act_d   = clamp(load_buf ? buf_act_q : i_act_limit);
         rec_d   = clamp(load_buf ? buf_rec_q : i_rec_limit);
         limit_d = su_d;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= S_IDLE;
         limit_q    <= '0;
         type_q     <= '0;
         su_q       <= '0;
         act_q      <= '0;
         rec_q      <= '0;
         buf_vld_q  <= 1'b0;
         buf_type_q <= '0;
         buf_su_q   <= '0;
         buf_act_q  <= '0;
         buf_rec_q  <= '0;
         stop_q     <= 1'b0;
         enable_q   <= 1'b0;
         accept_q   <= 1'b0;
         hitbox_q   <= 1'b0;
         move_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         type_q     <= type_d;
         su_q       <= su_d;
         act_q      <= act_d;
         rec_q      <= rec_d;
         buf_vld_q  <= buf_vld_d;
         buf_type_q <= buf_type_d;
         buf_su_q   <= buf_su_d;
         buf_act_q  <= buf_act_d;
         buf_rec_q  <= buf_rec_d;
         stop_q     <= go;
         enable_q   <= (state_d != S_IDLE);
         accept_q   <= load_new || load_buf;
         hitbox_q   <= (state_d == S_ACTIVE);
         move_q     <= (state_d == S_IDLE);
      end
   end

   assign o_cnt_enable  = enable_q;
   assign o_cnt_stop    = stop_q;
   assign o_cnt_limit   = limit_q;
   assign o_state       = state_q;
   assign o_attack_type = type_q;
   assign o_accept      = accept_q;
   assign o_hitbox_en   = hitbox_q;
   assign o_can_move    = move_q;
   assign o_buf_valid   = buf_vld_q;
endmodule

// File: tb/tb_attack_phase_sequencer.sv
// Bench for attack_phase_sequencer: directed plus random stimulus, a phase-duration reference
// model feeding an event queue, and a monitor that checks every event and every steady cycle.
`timescale 1ns/1ps
module tb_attack_phase_sequencer;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         nRst = 1'b0;
   logic         req = 1'b0, hit = 1'b0;
   logic [1:0]   typ = '0;
   logic [W-1:0] su = '0, act = '0, rec = '0, stun = '0;
   logic         cnt_done;
   logic         o_cnt_enable, o_cnt_stop, o_accept, o_hitbox_en, o_can_move, o_buf_valid;
   logic [W-1:0] o_cnt_limit;
   logic [2:0]   o_state;
   logic [1:0]   o_attack_type;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int           cyc;
      logic [2:0]   st;
      logic [W-1:0] lim;
      logic [1:0]   typ;
      logic         acc;
      logic         bv;
      logic         stop;
   } ev_t;
   ev_t q[$];

   // Reference: a phase of limit L simply lasts clamp(L)+2 ticks.
   int           m_state = 0, m_left = 0;
   logic [W-1:0] m_lim = '0, m_su = '0, m_act = '0, m_rec = '0;
   logic [1:0]   m_type = '0, m_bt = '0;
   logic         m_bv = 1'b0;
   logic [W-1:0] m_bs = '0, m_ba = '0, m_br = '0;

   logic [2:0]   exp_st = '0;
   logic         exp_bv = 1'b0;
   logic [W-1:0] exp_lim = '0;
   logic [1:0]   exp_typ = '0;

   attack_phase_sequencer dut (
      .clk(clk), .nRst(nRst),
      .i_attack_req(req), .i_attack_type(typ),
      .i_su_limit(su), .i_act_limit(act), .i_rec_limit(rec),
      .i_hit(hit), .i_stun_limit(stun), .i_cnt_done(cnt_done),
      .o_cnt_enable(o_cnt_enable), .o_cnt_stop(o_cnt_stop), .o_cnt_limit(o_cnt_limit),
      .o_state(o_state), .o_attack_type(o_attack_type), .o_accept(o_accept),
      .o_hitbox_en(o_hitbox_en), .o_can_move(o_can_move), .o_buf_valid(o_buf_valid)
   );

   always #5 clk = ~clk;

   // External duration counter; done may be stale during the clear cycle.
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) cnt_q <= '0;
      else if (o_cnt_stop) cnt_q <= '0;
      else if (o_cnt_enable) cnt_q <= (cnt_q == o_cnt_limit) ? '0 : cnt_q + 1'b1;
   end
   assign cnt_done = o_cnt_enable && (cnt_q == o_cnt_limit);

   function automatic logic [W-1:0] cl(input logic [W-1:0] v);
      return (v == '0) ? W'(1) : v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_left = 0; m_lim = '0; m_type = '0; m_bv = 1'b0;
      m_su = '0; m_act = '0; m_rec = '0;
   endtask

   task automatic model_step(input logic r, input logic [1:0] t, input logic [W-1:0] s,
                             input logic [W-1:0] a, input logic [W-1:0] c,
                             input logic h, input logic [W-1:0] sl);
      logic done, go, acc, use_buf, bv_old;
      int ns;
      logic [W-1:0] lim;
      ev_t e;
      done = (m_state != 0) && (m_left == 1);
      go = 1'b0; acc = 1'b0; use_buf = 1'b0; bv_old = m_bv; ns = m_state; lim = m_lim;
      if (h) begin
         ns = 4; lim = cl(sl); m_bv = 1'b0; go = 1'b1;
      end else if (m_state == 0) begin
         acc = r;
      end else if (m_state == 1) begin
         if (done) begin ns = 2; lim = m_act; go = 1'b1; end
      end else if (m_state == 2) begin
         if (r && t == 2'd2 && m_type != 2'd2) acc = 1'b1;
         else if (done) begin ns = 3; lim = m_rec; go = 1'b1; end
      end else if (m_state == 3) begin
         if (done) begin
            if (m_bv) begin acc = 1'b1; use_buf = 1'b1; m_bv = 1'b0; end
            else begin ns = 0; lim = '0; go = 1'b1; end
         end else if (r && !m_bv) begin
            m_bv = 1'b1; m_bt = t; m_bs = s; m_ba = a; m_br = c;
         end
      end else if (done) begin
         ns = 0; lim = '0; go = 1'b1;
      end
      if (acc) begin
         if (use_buf) begin m_type = m_bt; m_su = cl(m_bs); m_act = cl(m_ba); m_rec = cl(m_br); end
         else begin m_type = t; m_su = cl(s); m_act = cl(a); m_rec = cl(c); end
         ns = 1; lim = m_su; go = 1'b1;
      end
      if (go) begin m_state = ns; m_lim = lim; m_left = int'(lim) + 2; end
      else if (m_state != 0) m_left--;
      if (go || m_bv != bv_old) begin
         e.cyc = cyc; e.st = 3'(m_state); e.lim = m_lim; e.typ = m_type;
         e.acc = acc; e.bv = m_bv; e.stop = go;
         q.push_back(e);
      end
   endtask

   task automatic tick(input logic r, input logic [1:0] t, input logic [W-1:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] c,
                       input logic h, input logic [W-1:0] sl);
      req = r; typ = t; su = s; act = a; rec = c; hit = h; stun = sl;
      @(posedge clk);
      cyc++;
      model_step(r, t, s, a, c, h, sl);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 2'd0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic wait_state(input logic [2:0] s);
      int n = 0;
      while (o_state != s && n < 60) begin idle(1); n++; end
      checks++;
      if (o_state != s) begin
         errors++;
         $display("FAIL wait_state: state=%0d, required %0d within 60 cycles", o_state, s);
      end
   endtask

   task automatic check_reset(input string name);
      checks++;
      if ({o_state, o_cnt_enable, o_cnt_stop, o_cnt_limit, o_attack_type, o_accept,
           o_hitbox_en, o_can_move, o_buf_valid} !== {3'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s: st=%0d en=%0b stop=%0b lim=%0d typ=%0d acc=%0b hb=%0b mv=%0b bv=%0b, required idle reset values",
                  name, o_state, o_cnt_enable, o_cnt_stop, o_cnt_limit, o_attack_type, o_accept,
                  o_hitbox_en, o_can_move, o_buf_valid);
      end
   endtask

   // Monitor: pops one expected event per phase change or buffer change, else checks steadiness.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!nRst) begin
            exp_st = '0; exp_bv = 1'b0; exp_lim = '0; exp_typ = '0;
         end else if (o_cnt_stop || o_buf_valid != exp_bv) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d: st=%0d stop=%0b bv=%0b, required no event",
                        cyc, o_state, o_cnt_stop, o_buf_valid);
               exp_st = o_state; exp_bv = o_buf_valid; exp_lim = o_cnt_limit; exp_typ = o_attack_type;
            end else begin
               e = q.pop_front();
               if ({cyc, o_state, o_cnt_limit, o_attack_type, o_accept, o_buf_valid, o_cnt_stop,
                    o_cnt_enable, o_hitbox_en, o_can_move} !==
                   {e.cyc, e.st, e.lim, e.typ, e.acc, e.bv, e.stop,
                    e.st != 3'd0, e.st == 3'd2, e.st == 3'd0}) begin
                  errors++;
                  $display("FAIL event: got cyc=%0d st=%0d lim=%0d typ=%0d acc=%0b bv=%0b stop=%0b en=%0b hb=%0b mv=%0b, required cyc=%0d st=%0d lim=%0d typ=%0d acc=%0b bv=%0b stop=%0b",
                           cyc, o_state, o_cnt_limit, o_attack_type, o_accept, o_buf_valid, o_cnt_stop,
                           o_cnt_enable, o_hitbox_en, o_can_move,
                           e.cyc, e.st, e.lim, e.typ, e.acc, e.bv, e.stop);
               end
               exp_st = e.st; exp_bv = e.bv; exp_lim = e.lim; exp_typ = e.typ;
            end
         end else begin
            checks++;
            if ({o_state, o_cnt_limit, o_attack_type, o_accept, o_cnt_enable, o_hitbox_en, o_can_move} !==
                {exp_st, exp_lim, exp_typ, 1'b0, exp_st != 3'd0, exp_st == 3'd2, exp_st == 3'd0}) begin
               errors++;
               $display("FAIL steady cyc=%0d: got st=%0d lim=%0d typ=%0d acc=%0b en=%0b hb=%0b mv=%0b, required st=%0d lim=%0d typ=%0d acc=0",
                        cyc, o_state, o_cnt_limit, o_attack_type, o_accept, o_cnt_enable, o_hitbox_en,
                        o_can_move, exp_st, exp_lim, exp_typ);
            end
         end
      end
   end

   initial begin
      model_reset();
      @(negedge clk); @(negedge clk); #1;
      check_reset("reset_state");
      nRst = 1'b1;

      // Plain attack: 5 + 4 + 6 cycles.
      tick(1'b1, 2'd0, 5'd3, 5'd2, 5'd4, 1'b0, '0);
      idle(20);
      // Hit in second ACTIVE cycle.
      tick(1'b1, 2'd0, 5'd3, 5'd2, 5'd4, 1'b0, '0);
      wait_state(3'd2);
      idle(1);
      tick(1'b0, 2'd0, '0, '0, '0, 1'b1, 5'd5);
      idle(12);
      // Special cancel, then a second special that must be ignored.
      tick(1'b1, 2'd1, 5'd2, 5'd3, 5'd2, 1'b0, '0);
      wait_state(3'd2);
      tick(1'b1, 2'd2, 5'd1, 5'd4, 5'd1, 1'b0, '0);
      wait_state(3'd2);
      tick(1'b1, 2'd2, 5'd6, 5'd6, 5'd6, 1'b0, '0);
      idle(30);
      // Buffered request: first one wins.
      tick(1'b1, 2'd1, 5'd1, 5'd1, 5'd6, 1'b0, '0);
      wait_state(3'd3);
      tick(1'b1, 2'd1, 5'd2, 5'd2, 5'd2, 1'b0, '0);
      tick(1'b1, 2'd0, 5'd4, 5'd4, 5'd4, 1'b0, '0);
      idle(40);
      // Hit beats request in IDLE, then re-hit mid-STUN.
      tick(1'b1, 2'd0, 5'd2, 5'd2, 5'd2, 1'b1, 5'd4);
      idle(2);
      tick(1'b0, 2'd0, '0, '0, '0, 1'b1, 5'd7);
      idle(15);
      // All-zero limits clamp to 1.
      tick(1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 1'b0, '0);
      idle(15);
      // Reset mid-STARTUP.
      tick(1'b1, 2'd1, 5'd0, 5'd0, 5'd0, 1'b0, '0);
      idle(1);
      nRst = 1'b0;
      #1;
      check_reset("mid_reset");
      q.delete();
      model_reset();
      @(negedge clk); #1;
      nRst = 1'b1;

      for (int i = 0; i < 2500; i++) begin
         tick(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
              ($urandom_range(0, 31) == 0), W'($urandom_range(0, 7)));
      end
      idle(40);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected events never observed, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
